// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port between the MEM/WB
//            pipeline writeback (always wins) and a multicycle unit whose
//            results are buffered in a small FIFO. Requests a front-end
//            stall when buffered results stay blocked for too long.
// Ports    : clk, rst_n (async, active-low)
//            wb_regwrite/wb_rd/wb_data    - pipeline writeback request
//            mc_valid/mc_rd/mc_data       - multicycle result (in)
//            mc_ready                     - FIFO can accept a result
//            rf_we/rf_waddr/rf_wdata      - register file write port
//            pending_mask                 - per-register pending FIFO writes
//            stall_req                    - registered stall request
// Options  : WB_ARB_BYPASS_EN - when defined, a result that arrives while the
//            FIFO is empty and the slot is idle goes straight to the port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [63:0] mc_data,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [31:0] pending_mask,
    output logic        stall_req
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);
    localparam logic [3:0]    c_starve_lim = 4'(STARVE_LIMIT);

    // FIFO state
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_vld;
    logic [4:0]       r_rd   [DEPTH];
    logic [63:0]      r_data [DEPTH];

    // Starvation tracking
    logic [3:0] r_starve;
    logic       r_stall;

    logic       w_pbusy;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_bypass;
    logic [3:0] w_starve_next;
    logic [4:0] w_head_rd;

    assign w_pbusy   = wb_regwrite && (wb_rd != 5'd0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    assign w_pop     = !w_pbusy && !w_empty;
    assign w_head_rd = r_rd[r_rptr];

`ifdef WB_ARB_BYPASS_EN
    assign w_bypass = w_empty && !w_pbusy && mc_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // No pass-through when full, even if the head pops this cycle.
    assign mc_ready  = !w_full;
    assign w_push    = mc_valid && !w_full && !w_bypass;
    assign stall_req = r_stall;

    // Write-port mux. rd=0 entries are popped but never written.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 64'd0;
        if (w_pbusy) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (!w_empty) begin
            if (w_head_rd != 5'd0) begin
                rf_we    = 1'b1;
                rf_waddr = w_head_rd;
                rf_wdata = r_data[r_rptr];
            end
        end else if (w_bypass && (mc_rd != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = mc_rd;
            rf_wdata = mc_data;
        end
        // Keep the register file untouched while reset is held.
        if (!rst_n) begin
            rf_we = 1'b0;
        end
    end

    // One-hot OR of destination registers still waiting in the FIFO.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_rd[i] != 5'd0)) begin
                pending_mask[r_rd[i]] = 1'b1;
            end
        end
    end

    // Counter only advances while a queued entry is blocked by the pipe.
    always_comb begin
        w_starve_next = r_starve;
        if (w_pop || w_empty) begin
            w_starve_next = 4'd0;
        end else if (w_pbusy && (r_starve != 4'hF)) begin
            w_starve_next = r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            r_starve <= 4'd0;
            r_stall  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr        <= r_wptr + 1'b1;
                r_vld[r_wptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rptr        <= r_rptr + 1'b1;
                r_vld[r_rptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_starve <= w_starve_next;
            if (w_pop) begin
                r_stall <= 1'b0;
            end else if (!w_empty && w_pbusy && (w_starve_next == c_starve_lim)) begin
                r_stall <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: validity is tracked by r_vld/r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= mc_rd;
            r_data[r_wptr] <= mc_data;
        end
    end

endmodule
`default_nettype wire
